// File: rtl/program_loader_if.sv
// Bundle between the byte-stream host, the program loader and program memory.
// The loader takes the slave side; the host/bench drives through master.
interface program_loader_if #(
  parameter int WIDTH     = 32,
  parameter int ADD_WIDTH = 8
);
  logic                 load_en;
  logic                 byte_valid;
  logic [7:0]           byte_in;
  logic                 byte_ready;
  logic                 mem_wen;
  logic [ADD_WIDTH-1:0] mem_add;
  logic [WIDTH-1:0]     mem_wdata;
  logic                 cpu_rst;
  logic                 load_done;
  logic [ADD_WIDTH:0]   word_count;

  modport master (
    output load_en, byte_valid, byte_in,
    input  byte_ready, mem_wen, mem_add, mem_wdata, cpu_rst, load_done, word_count
  );

  modport slave (
    input  load_en, byte_valid, byte_in,
    output byte_ready, mem_wen, mem_add, mem_wdata, cpu_rst, load_done, word_count
  );
endinterface

// File: rtl/program_loader.sv
// Streams program bytes into 32-bit little-endian words, writes them to program
// memory from address 0, and keeps the CPU core in reset until the load ends.
module program_loader #(
  parameter int WIDTH     = 32,
  parameter int ADD_WIDTH = 8,
  parameter int DEPTH     = 256
) (
  input  logic           clk,
  input  logic           rst,
  program_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
    S_DONE    = 3'd3,
    S_RUN     = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           byte_idx_q, byte_idx_d;
  logic [WIDTH-1:0]     asm_q, asm_d;
  logic [WIDTH-1:0]     asm_fill;
  // The written-word count doubles as the write pointer; the extra MSB lets it reach DEPTH.
  logic [ADD_WIDTH:0]   wcnt_q, wcnt_d;
  logic                 byte_ready_q, byte_ready_d;
  logic                 mem_wen_q, mem_wen_d;
  logic [ADD_WIDTH-1:0] mem_add_q, mem_add_d;
  logic [WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
  logic                 cpu_rst_q, cpu_rst_d;
  logic                 load_done_q, load_done_d;

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      byte_idx_q   <= 2'd0;
      asm_q        <= '0;
      wcnt_q       <= '0;
      byte_ready_q <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_add_q    <= '0;
      mem_wdata_q  <= '0;
      cpu_rst_q    <= 1'b1;
      load_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      asm_q        <= asm_d;
      wcnt_q       <= wcnt_d;
      byte_ready_q <= byte_ready_d;
      mem_wen_q    <= mem_wen_d;
      mem_add_q    <= mem_add_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rst_q    <= cpu_rst_d;
      load_done_q  <= load_done_d;
    end
  end

  // Next-state and next-output logic; outputs are decoded from the next state
  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    asm_d       = asm_q;
    wcnt_d      = wcnt_q;
    mem_add_d   = mem_add_q;
    mem_wdata_d = mem_wdata_q;
    asm_fill    = asm_q;
    asm_fill[{byte_idx_q, 3'b000} +: 8] = bus.byte_in;

    case (state_q)
      S_IDLE, S_RUN: begin
        if (bus.load_en) begin
          state_d    = S_COLLECT;
          byte_idx_d = 2'd0;
          asm_d      = '0;
          wcnt_d     = '0;
        end else begin
          state_d = state_q;
        end
      end
      S_COLLECT: begin
        // Dropping load_en wins over a byte offered in the same cycle.
        if (!bus.load_en) begin
          if (byte_idx_q == 2'd0) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_WRITE;
            mem_add_d   = wcnt_q[ADD_WIDTH-1:0];
            mem_wdata_d = asm_q;
          end
        end else if (bus.byte_valid && byte_ready_q) begin
          byte_idx_d = byte_idx_q + 2'd1;
          asm_d      = asm_fill;
          if (byte_idx_q == 2'd3) begin
            state_d     = S_WRITE;
            mem_add_d   = wcnt_q[ADD_WIDTH-1:0];
            mem_wdata_d = asm_fill;
          end else begin
            state_d = S_COLLECT;
          end
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_WRITE: begin
        wcnt_d     = wcnt_q + (ADD_WIDTH + 1)'(1);
        byte_idx_d = 2'd0;
        asm_d      = '0;
        if ((mem_add_q == ADD_WIDTH'(DEPTH - 1)) || !bus.load_en) begin
          state_d = S_DONE;
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_DONE: begin
        if (!bus.load_en) begin
          state_d = S_RUN;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    byte_ready_d = (state_d == S_COLLECT) && bus.load_en;
    mem_wen_d    = (state_d == S_WRITE);
    cpu_rst_d    = (state_d != S_RUN);
    load_done_d  = (state_d == S_DONE);
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.mem_wen    = mem_wen_q;
  assign bus.mem_add    = mem_add_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.cpu_rst    = cpu_rst_q;
  assign bus.load_done  = load_done_q;
  assign bus.word_count = wcnt_q;

endmodule
